conv_cal_ctrl: RTL and testbench

//  Sequencer for the 3x3 int8 conv MAC pipeline (conv_cal).
//  - Loads the 72-bit weight word once per job and drives the group flip select.
//  - Streams 24-bit input words from the input SRAM; one word per cycle, three words per output pixel.
//  - Tracks pipeline latency with a tag shift register and writes each 32-bit result to the output SRAM.
//  - Sits between the layer scheduler (start/done) and the buffers plus the MAC.

---
 rtl/conv_ctrl_pkg.sv | 28 ++
 rtl/conv_tag_pipe.sv | 41 ++++
 rtl/conv_cal_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_conv_cal_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the conv MAC sequencer: FSM states, pipeline timing, output tag.
// Pure declarations: no latency and no flow control of its own.
package conv_ctrl_pkg;

    localparam int AW        = 12;
    localparam int DW        = 12;
    localparam int FEED_CYC  = 3;
    localparam int PIPE_LAT  = 6;
    localparam int TAG_DEPTH = 1 + PIPE_LAT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_WLD,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_t;

    // Valid sits in the MSB so the tag pipe can detect occupancy without knowing the layout.
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] oaddr;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/conv_tag_pipe.sv
// Fixed-depth tag delay line with synchronous clear; the MSB of each entry is its valid bit.
// Latency DEPTH cycles from push to tail; never stalls, a push is accepted every cycle.
module conv_tag_pipe
    import conv_ctrl_pkg::*;
#(
    parameter int W     = TAG_W,
    parameter int DEPTH = TAG_DEPTH
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_push_vld,
    input  logic [W-1:0] i_push_dat,
    output logic [W-1:0] o_tail_dat,
    output logic         o_any_vld
);

    logic [W-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_push_vld ? i_push_dat : '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    always_comb begin
        o_any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            o_any_vld = o_any_vld | r_stage[i][W-1];
        end
    end

    assign o_tail_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/conv_cal_ctrl.sv
// Job sequencer for the 3x3 conv MAC: weight load, input streaming, result write-back; no backpressure.
// Result n written T0+3n+1+PIPE_LAT; CONV_CTRL_RELU_EN clamps negative results to zero.
module conv_cal_ctrl
    import conv_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] cfg_width,
    input  logic [DW-1:0] cfg_height,
    input  logic          cfg_group,
    input  logic [AW-1:0] cfg_in_base,
    input  logic [AW-1:0] cfg_out_base,
    input  logic [AW-1:0] cfg_w_addr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          w_ren,
    output logic [AW-1:0] w_raddr,
    output logic          w_load,
    output logic          group,
    output logic          ib_ren,
    output logic [AW-1:0] ib_addr,
    input  logic [31:0]   ans_in,
    output logic          ob_wen,
    output logic [AW-1:0] ob_addr,
    output logic [31:0]   ob_wdata
);

    state_t        r_state;
    logic          r_wld_ph;
    logic [DW-1:0] r_width;
    logic [DW-1:0] r_height;
    logic [AW-1:0] r_in_base;
    logic [AW-1:0] r_out_base;
    logic [1:0]    r_k;
    logic [DW-1:0] r_r;
    logic [DW-1:0] r_c;
    logic [AW-1:0] r_pix_addr;
    logic [AW-1:0] r_oaddr;
    logic          r_pipe_idle;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_w_ren;
    logic [AW-1:0] r_w_raddr;
    logic          r_w_load;
    logic          r_group;
    logic          r_ib_ren;
    logic [AW-1:0] r_ib_addr;

    logic          w_k_last;
    logic          w_c_last;
    logic          w_r_last;
    logic          w_push;
    logic [AW-1:0] w_stride;
    logic [AW-1:0] w_next_pix;
    logic          w_any_vld;
    tag_t          w_push_tag;
    tag_t          w_tail_tag;

    assign w_k_last   = (r_k == 2'(FEED_CYC - 1));
    assign w_c_last   = (r_c == r_width - DW'(3));
    assign w_r_last   = (r_r == r_height - DW'(3));
    assign w_push     = (r_state == ST_RUN) && (r_k == 2'd0);
    assign w_stride   = AW'(r_width);
    // Stepping from the last column of a row to column 0 of the next row moves 3 words forward.
    assign w_next_pix = r_pix_addr + (w_c_last ? AW'(3) : AW'(1));
    assign w_push_tag = '{valid: 1'b1, oaddr: r_oaddr};

    conv_tag_pipe #(
        .W     (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .clk        (clk),
        .i_clr      (rst),
        .i_push_vld (w_push),
        .i_push_dat (w_push_tag),
        .o_tail_dat (w_tail_tag),
        .o_any_vld  (w_any_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wld_ph    <= 1'b0;
            r_width     <= '0;
            r_height    <= '0;
            r_in_base   <= '0;
            r_out_base  <= '0;
            r_k         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_pix_addr  <= '0;
            r_oaddr     <= '0;
            r_pipe_idle <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_w_ren     <= 1'b0;
            r_w_raddr   <= '0;
            r_w_load    <= 1'b0;
            r_group     <= 1'b0;
            r_ib_ren    <= 1'b0;
            r_ib_addr   <= '0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            // Registered so DRAIN waits one extra cycle after the last tag leaves.
            r_pipe_idle <= ~w_any_vld;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_width    <= cfg_width;
                        r_height   <= cfg_height;
                        r_group    <= cfg_group;
                        r_in_base  <= cfg_in_base;
                        r_out_base <= cfg_out_base;
                        r_w_raddr  <= cfg_w_addr;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (r_width < DW'(3) || r_height < DW'(3)) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_FIN;
                    end else begin
                        r_w_ren  <= 1'b1;
                        r_wld_ph <= 1'b0;
                        r_state  <= ST_WLD;
                    end
                end
                ST_WLD: begin
                    if (!r_wld_ph) begin
                        r_w_ren  <= 1'b0;
                        r_w_load <= 1'b1;
                        r_wld_ph <= 1'b1;
                    end else begin
                        r_w_load   <= 1'b0;
                        r_ib_ren   <= 1'b1;
                        r_ib_addr  <= r_in_base;
                        r_pix_addr <= r_in_base;
                        r_oaddr    <= r_out_base;
                        r_k        <= '0;
                        r_r        <= '0;
                        r_c        <= '0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_push) begin
                        r_oaddr <= r_oaddr + AW'(1);
                    end
                    if (!w_k_last) begin
                        r_k       <= r_k + 2'd1;
                        r_ib_addr <= r_ib_addr + w_stride;
                    end else if (w_r_last && w_c_last) begin
                        r_ib_ren <= 1'b0;
                        r_state  <= ST_DRAIN;
                    end else begin
                        r_k        <= '0;
                        r_ib_addr  <= w_next_pix;
                        r_pix_addr <= w_next_pix;
                        if (w_c_last) begin
                            r_c <= '0;
                            r_r <= r_r + DW'(1);
                        end else begin
                            r_c <= r_c + DW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_pipe_idle) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign w_ren   = r_w_ren;
    assign w_raddr = r_w_raddr;
    assign w_load  = r_w_load;
    assign group   = r_group;
    assign ib_ren  = r_ib_ren;
    assign ib_addr = r_ib_addr;
    assign ob_wen  = w_tail_tag.valid;
    assign ob_addr = w_tail_tag.oaddr;

`ifdef CONV_CTRL_RELU_EN
    assign ob_wdata = (w_tail_tag.valid && !ans_in[31]) ? ans_in : 32'd0;
`else
    assign ob_wdata = w_tail_tag.valid ? ans_in : 32'd0;
`endif

endmodule

// File: tb/tb_conv_cal_ctrl.sv
// Scoreboard bench for conv_cal_ctrl: expected reads/writes queued at job start, checked as the DUT emits them.
module tb_conv_cal_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] cfg_width = '0;
    logic [11:0] cfg_height = '0;
    logic        cfg_group = 1'b0;
    logic [11:0] cfg_in_base = '0;
    logic [11:0] cfg_out_base = '0;
    logic [11:0] cfg_w_addr = '0;
    logic [31:0] ans_in = '0;
    logic        busy, done, err, w_ren, w_load, group, ib_ren, ob_wen;
    logic [11:0] w_raddr, ib_addr, ob_addr;
    logic [31:0] ob_wdata;

    conv_cal_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_group    (cfg_group),
        .cfg_in_base  (cfg_in_base),
        .cfg_out_base (cfg_out_base),
        .cfg_w_addr   (cfg_w_addr),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .w_ren        (w_ren),
        .w_raddr      (w_raddr),
        .w_load       (w_load),
        .group        (group),
        .ib_ren       (ib_ren),
        .ib_addr      (ib_addr),
        .ans_in       (ans_in),
        .ob_wen       (ob_wen),
        .ob_addr      (ob_addr),
        .ob_wdata     (ob_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] relu_model(input logic [31:0] a);
`ifdef CONV_CTRL_RELU_EN
        return a[31] ? 32'd0 : a;
`else
        return a;
`endif
    endfunction

    logic [11:0] exp_rd[$];
    logic [11:0] exp_wa[$];
    int          exp_wc[$];
    bit          mon_chk = 1'b0;
    int          t_start = 0;
    logic [11:0] exp_waddr = '0;
    logic        exp_group = 1'b0;
    int          done_cnt = 0, done_cyc = 0, wren_cnt = 0, wload_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    logic        done_err = 1'b0;
    logic [11:0] m_addr;
    int          m_cyc;

    // MAC result model: odd cycles present a negative value, even cycles a random positive one.
    initial forever begin
        @(posedge clk);
        #2;
        ans_in = cyc[0] ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 32'h7FFF_FFFF));
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
            check_eq("busy_at_done", {31'd0, busy}, 32'd0);
        end
        if (err && !done) check_eq("err_without_done", {31'd0, err}, 32'd0);
        if (mon_chk && cyc == t_start + 1) check_eq("busy_rise", {31'd0, busy}, 32'd1);
        if (w_ren) begin
            wren_cnt++;
            if (mon_chk) begin
                check_eq("w_raddr", w_raddr, exp_waddr);
                check_eq("w_ren_cyc", cyc, t_start + 2);
            end
        end
        if (w_load) begin
            wload_cnt++;
            if (mon_chk) begin
                check_eq("w_load_cyc", cyc, t_start + 3);
                check_eq("group", {31'd0, group}, {31'd0, exp_group});
            end
        end
        if (ib_ren) begin
            rd_cnt++;
            if (mon_chk) begin
                if (exp_rd.size() == 0) check_eq("rd_extra", {31'd0, ib_ren}, 32'd0);
                else begin
                    m_addr = exp_rd.pop_front();
                    check_eq("rd_addr", ib_addr, m_addr);
                end
            end
        end
        if (ob_wen) begin
            wr_cnt++;
            if (mon_chk) begin
                if (exp_wa.size() == 0) check_eq("wr_extra", {31'd0, ob_wen}, 32'd0);
                else begin
                    m_addr = exp_wa.pop_front();
                    m_cyc  = exp_wc.pop_front();
                    check_eq("wr_addr", ob_addr, m_addr);
                    check_eq("wr_cyc", cyc, m_cyc);
                    check_eq("wr_data", ob_wdata, relu_model(ans_in));
                end
            end
        end
    end

    task automatic run_job(input int w, input int h, input logic [11:0] ib, input logic [11:0] ob,
                           input logic [11:0] wa, input logic grp, input bit mid_start);
        int  npix, n, exp_done;
        bit  bad;
        bad  = (w < 3) || (h < 3);
        npix = bad ? 0 : (w - 2) * (h - 2);
        @(posedge clk);
        #1;
        cfg_width    = 12'(w);
        cfg_height   = 12'(h);
        cfg_group    = grp;
        cfg_in_base  = ib;
        cfg_out_base = ob;
        cfg_w_addr   = wa;
        start        = 1'b1;
        t_start      = cyc;
        exp_waddr    = wa;
        exp_group    = grp;
        done_cnt = 0; wren_cnt = 0; wload_cnt = 0;
        mon_chk      = 1'b1;
        for (int r = 0; r < h - 2; r++) begin
            for (int c = 0; c < w - 2; c++) begin
                n = r * (w - 2) + c;
                for (int k = 0; k < 3; k++) exp_rd.push_back(ib + 12'((r + k) * w + c));
                exp_wa.push_back(ob + 12'(n));
                exp_wc.push_back(t_start + 11 + 3 * n);
            end
        end
        exp_done = bad ? t_start + 2 : t_start + 11 + 3 * npix;
        @(posedge clk);
        #1;
        start        = 1'b0;
        cfg_width    = 12'd9;
        cfg_height   = 12'd9;
        cfg_group    = ~grp;
        cfg_in_base  = 12'h555;
        cfg_out_base = 12'hAAA;
        cfg_w_addr   = 12'h777;
        if (mid_start) begin
            repeat (5) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
        #1;
        check_eq("done_cnt", done_cnt, 1);
        check_eq("done_cyc", done_cyc, exp_done);
        check_eq("done_err", {31'd0, done_err}, {31'd0, bad});
        check_eq("w_ren_cnt", wren_cnt, bad ? 0 : 1);
        check_eq("w_load_cnt", wload_cnt, bad ? 0 : 1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("done_once", done_cnt, 1);
        check_eq("rd_left", exp_rd.size(), 0);
        check_eq("wr_left", exp_wa.size(), 0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic abort_job();
        mon_chk = 1'b0;
        @(posedge clk);
        #1;
        cfg_width = 12'd5; cfg_height = 12'd4;
        cfg_in_base = 12'h040; cfg_out_base = 12'h080; cfg_w_addr = 12'h001;
        start = 1'b1;
        t_start = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("abort_in_run", {31'd0, ib_ren}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_ib_ren", {31'd0, ib_ren}, 32'd0);
        check_eq("abort_w_ren", {31'd0, w_ren}, 32'd0);
        check_eq("abort_w_load", {31'd0, w_load}, 32'd0);
        check_eq("abort_ob_wen", {31'd0, ob_wen}, 32'd0);
        done_cnt = 0; rd_cnt = 0; wr_cnt = 0; wren_cnt = 0;
        repeat (30) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_no_rd", rd_cnt, 0);
        check_eq("abort_no_wr", wr_cnt, 0);
        check_eq("abort_no_wren", wren_cnt, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_w_ren", {31'd0, w_ren}, 32'd0);
        check_eq("rst_ib_ren", {31'd0, ib_ren}, 32'd0);
        check_eq("rst_ob_wen", {31'd0, ob_wen}, 32'd0);
        check_eq("rst_addrs", {8'd0, w_raddr, ib_addr}, 32'd0);
        check_eq("rst_wdata", ob_wdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run_job(3, 3, 12'h000, 12'h000, 12'h0AB, 1'b1, 1'b0);
        run_job(5, 4, 12'h100, 12'h200, 12'h010, 1'b0, 1'b0);
        run_job(2, 5, 12'h100, 12'h200, 12'h010, 1'b1, 1'b0);
        run_job(6, 2, 12'h100, 12'h200, 12'h010, 1'b0, 1'b0);
        run_job(4, 5, 12'hFF0, 12'hFFE, 12'h3C3, 1'b1, 1'b1);
        abort_job();
        run_job(3, 4, 12'h020, 12'h030, 12'h005, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
